nn_img_bf_mb: RTL and testbench
===============================

# nn_img_bf_mb

Parametrised, lane-masked image buffer; next generation of the fake synchronous image buffer feeding the PE array. Stores LANES pixels of DATA_WIDTH bits per word and supports a simultaneous write and read every cycle. Adds per-lane write masking, a registered read port with valid strobe, out-of-range detection, and optional write-to-read bypass. Sits between the DMA/image loader (write side) and the convolution input shifter (read side).

## Interface

- DATA_WIDTH, 8, bits per pixel lane
- LANES, 6, pixel lanes per word; word width W = DATA_WIDTH*LANES
- ADDR_WIDTH, 12, address port width
- DEPTH, 1024, implemented words; must satisfy 1 <= DEPTH <= 2^ADDR_WIDTH

- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_wr_en  input  1  write request this cycle
- i_wr_addr  input  ADDR_WIDTH  write word address
- i_wr_data  input  W  write data, lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_wr_mask  input  LANES  per-lane write enable; lane k written only if bit k = 1
- i_rd_en  input  1  read request this cycle
- i_rd_addr  input  ADDR_WIDTH  read word address
- o_rd_data  output  W  registered read data
- o_rd_valid  output  1  one-cycle strobe: o_rd_data holds result of a read
- o_rd_err  output  1  one-cycle strobe: that read addressed >= DEPTH
- o_wr_err  output  1  one-cycle strobe: previous-cycle write addressed >= DEPTH

## Operation

- Storage: DEPTH x W array; contents not reset, undefined until written.
- Write: at rising edge with i_wr_en=1 and i_wr_addr < DEPTH, lanes with i_wr_mask[k]=1 updated; other lanes keep old value. i_wr_mask=0 is a legal no-op.
- Write with i_wr_addr >= DEPTH: array unchanged; o_wr_err=1 next cycle.
- Read: independent of write; no priority between ports (unlike the previous block, a write does not block a read).
- Read with i_rd_addr < DEPTH: o_rd_data <= array[i_rd_addr]; o_rd_valid=1, o_rd_err=0.
- Read with i_rd_addr >= DEPTH: o_rd_data <= 0; o_rd_valid=1, o_rd_err=1.
- No read (i_rd_en=0): o_rd_data holds last value; o_rd_valid=0, o_rd_err=0.
- Same-address read and write in one cycle: governed by Configuration.
- Addresses compared at full ADDR_WIDTH; no wrap-around or truncation.

## Timing

- Reset values: o_rd_data=0, o_rd_valid=0, o_rd_err=0, o_wr_err=0.
- Reset asserted mid-operation: read in flight discarded (valid not raised); write sampled on the same edge as reset assertion not guaranteed; array otherwise retained.
- Read latency 1: request sampled at edge N, data/valid/err visible after edge N until edge N+1.
- Back-to-back reads each cycle: o_rd_valid stays 1, new data every cycle, full throughput.
- Write visible to a read sampled at any later edge (N+1 onward).
- o_wr_err asserted for exactly the cycle after the offending write edge.

## Configuration

- NN_IMG_BF_MB_BYPASS_EN defined: same-cycle read and write to same in-range address returns merged word: masked lanes from i_wr_data, unmasked lanes from old array contents (write-first).
- Undefined: same-cycle collision returns old array contents entirely (read-first); write still lands at the edge.
- Out-of-range collisions return 0 in both builds.

## Test plan

- Reset: assert i_rst between edges -> all outputs 0 immediately; release, no requests -> o_rd_valid stays 0.
- Write addr 5 data 0x0605_0403_0201, mask 6'h3F; next cycle read 5 -> after one edge o_rd_data=0x060504030201, o_rd_valid=1, o_rd_err=0.
- Masked write addr 5 data 0xFFFF_FFFF_FFFF mask 6'b000101 then read 5 -> 0x0605_04FF_02FF.
- Collision: addr 7 holds 0x111111111111; same cycle write 0x222222222222 mask 6'h3F and read 7 -> BYPASS_EN build 0x222222222222, otherwise 0x111111111111; following read 0x222222222222 in both.
- Out of range (DEPTH=1024): write addr 1024 -> o_wr_err=1 one cycle, no array change; read addr 4095 -> o_rd_data=0, o_rd_valid=1, o_rd_err=1.
- Streaming: read addrs 0..15 on consecutive cycles after filling them -> 16 consecutive valid cycles, data in order; drop i_rd_en -> o_rd_valid=0, o_rd_data holds word 15.

Source files
------------

// File: rtl/nn_img_bf_mb.sv
// Lane-masked dual-port image buffer with registered read port and range checking.
// Optional same-address write-to-read bypass is enabled by defining NN_IMG_BF_MB_BYPASS_EN.
module nn_img_bf_mb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 6,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [ADDR_WIDTH-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH*LANES-1:0]   i_wr_data,
    input  logic [LANES-1:0]              i_wr_mask,
    input  logic                          i_rd_en,
    input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
    output logic [DATA_WIDTH*LANES-1:0]   o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_rd_err,
    output logic                          o_wr_err
);

    localparam int unsigned W     = DATA_WIDTH * LANES;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable in the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [W-1:0]     rd_word;

    logic [W-1:0]     rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic             wr_err_q, wr_err_d;

    // Full-width compare: out-of-range addresses never alias onto implemented words.
    assign wr_in_range = ({1'b0, i_wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, i_rd_addr} < DEPTH_EXT);
    assign wr_fire     = i_wr_en & wr_in_range;
    assign wr_idx      = i_wr_addr[IDX_W-1:0];
    assign rd_idx      = i_rd_addr[IDX_W-1:0];

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (i_wr_mask[k]) begin
                    mem_q[wr_idx][k*DATA_WIDTH +: DATA_WIDTH] <=
                        i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = rd_in_range ? mem_q[rd_idx] : '0;
`ifdef NN_IMG_BF_MB_BYPASS_EN
        // Write-first collision: masked lanes come straight from the write port.
        if (wr_fire && rd_in_range && (i_wr_addr == i_rd_addr)) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (i_wr_mask[k]) begin
                    rd_word[k*DATA_WIDTH +: DATA_WIDTH] = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
`endif
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = i_rd_en;
        rd_err_d   = i_rd_en & ~rd_in_range;
        wr_err_d   = i_wr_en & ~wr_in_range;
        if (i_rd_en) begin
            rd_data_d = rd_word;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_err   = rd_err_q;
    assign o_wr_err   = wr_err_q;

endmodule

// File: tb/tb_nn_img_bf_mb.sv
// Scoreboard bench for nn_img_bf_mb; expected read results are queued at request time.
module tb_nn_img_bf_mb;

    localparam int unsigned DW = 8;
    localparam int unsigned LN = 6;
    localparam int unsigned AW = 12;
    localparam int unsigned DP = 1024;
    localparam int unsigned W  = DW * LN;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [LN-1:0] wr_mask;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_err;
    logic          wr_err;

    exp_t          sb[$];
    exp_t          e;
    logic [W-1:0]  model [16];
    int            n_checks;
    int            n_pass;

    nn_img_bf_mb #(
        .DATA_WIDTH(DW),
        .LANES     (LN),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_wr_mask (wr_mask),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_rd_valid(rd_valid),
        .o_rd_err  (rd_err),
        .o_wr_err  (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [LN-1:0] m);
        idle();
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
        tick();
        idle();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle();
        tick();
        tick();
        n_checks++;
        if ({rd_data, rd_valid, rd_err, wr_err} !== '0)
            $display("FAIL reset_values got data=%h v=%b re=%b we=%b required all 0",
                     rd_data, rd_valid, rd_err, wr_err);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || rd_err !== 1'b0 || wr_err !== 1'b0)
                $display("FAIL reset_idle_%0d got v=%b re=%b we=%b required 0", i, rd_valid,
                         rd_err, wr_err);
            else n_pass++;
        end
    endtask

    task automatic test_basic;
        do_write(12'd5, 48'h0605_0403_0201, 6'h3F);
        n_checks++;
        if (wr_err !== 1'b0) $display("FAIL basic_wr_err got %b required 0", wr_err);
        else n_pass++;
        rd_en   = 1'b1;
        rd_addr = 12'd5;
        sb.push_back('{data: 48'h0605_0403_0201, err: 1'b0});
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL basic_read valid got %b required 1", rd_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (rd_data !== e.data || rd_err !== e.err)
                $display("FAIL basic_read got %h err %b required %h err %b", rd_data, rd_err,
                         e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_mask;
        do_write(12'd5, 48'hFFFF_FFFF_FFFF, 6'b000101);
        rd_en   = 1'b1;
        rd_addr = 12'd5;
        sb.push_back('{data: 48'h0605_04FF_02FF, err: 1'b0});
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL mask_read valid got %b required 1", rd_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (rd_data !== e.data || rd_err !== e.err)
                $display("FAIL mask_read got %h err %b required %h err %b", rd_data, rd_err,
                         e.data, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_collision;
        logic [W-1:0] coll [2];
        logic [W-1:0] after [2];
        do_write(12'd7, 48'h1111_1111_1111, 6'h3F);
        do_write(12'd8, 48'hAAAA_AAAA_AAAA, 6'h3F);
`ifdef NN_IMG_BF_MB_BYPASS_EN
        coll[0] = 48'h2222_2222_2222;
        coll[1] = 48'h5555_AAAA_AAAA;
`else
        coll[0] = 48'h1111_1111_1111;
        coll[1] = 48'hAAAA_AAAA_AAAA;
`endif
        after[0] = 48'h2222_2222_2222;
        after[1] = 48'h5555_AAAA_AAAA;
        for (int i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            wr_addr = AW'(7 + i);
            wr_data = (i == 0) ? 48'h2222_2222_2222 : 48'h5555_5555_5555;
            wr_mask = (i == 0) ? 6'h3F : 6'b110000;
            rd_en   = 1'b1;
            rd_addr = AW'(7 + i);
            sb.push_back('{data: coll[i], err: 1'b0});
            tick();
            idle();
            rd_en   = 1'b1;
            rd_addr = AW'(7 + i);
            sb.push_back('{data: after[i], err: 1'b0});
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (rd_valid !== 1'b1 || sb.size() == 0) begin
                    $display("FAIL collision_%0d_%0d valid got %b required 1", i, j, rd_valid);
                    if (sb.size() != 0) void'(sb.pop_front());
                end else begin
                    e = sb.pop_front();
                    if (rd_data !== e.data || rd_err !== e.err)
                        $display("FAIL collision_%0d_%0d got %h err %b required %h err %b", i, j,
                                 rd_data, rd_err, e.data, e.err);
                    else n_pass++;
                end
                if (j == 0) tick();
                idle();
            end
        end
    endtask

    task automatic test_out_of_range;
        do_write(12'd0, 48'hC0FF_EE12_3456, 6'h3F);
        do_write(12'd1024, 48'hDEAD_BEEF_0000, 6'h3F);
        n_checks++;
        if (wr_err !== 1'b1) $display("FAIL oor_wr_err got %b required 1", wr_err);
        else n_pass++;
        tick();
        n_checks++;
        if (wr_err !== 1'b0) $display("FAIL oor_wr_err_clear got %b required 0", wr_err);
        else n_pass++;
        // Reads: word 0 unchanged, 4095 and 1024 return 0 with error, then OOR collision.
        for (int i = 0; i < 4; i++) begin
            idle();
            rd_en = 1'b1;
            case (i)
                0: begin rd_addr = 12'd0;    sb.push_back('{data: 48'hC0FF_EE12_3456, err: 1'b0}); end
                1: begin rd_addr = 12'd4095; sb.push_back('{data: '0, err: 1'b1}); end
                2: begin rd_addr = 12'd1024; sb.push_back('{data: '0, err: 1'b1}); end
                default: begin
                    rd_addr = 12'd1030;
                    wr_en   = 1'b1;
                    wr_addr = 12'd1030;
                    wr_data = 48'h1234_5678_9ABC;
                    wr_mask = 6'h3F;
                    sb.push_back('{data: '0, err: 1'b1});
                end
            endcase
            tick();
            idle();
            n_checks++;
            if (rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL oor_read_%0d valid got %b required 1", i, rd_valid);
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || rd_err !== e.err)
                    $display("FAIL oor_read_%0d got %h err %b required %h err %b", i, rd_data,
                             rd_err, e.data, e.err);
                else n_pass++;
            end
        end
        n_checks++;
        if (wr_err !== 1'b1) $display("FAIL oor_coll_wr_err got %b required 1", wr_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) begin
            model[i] = {$urandom(), 16'($urandom())};
            do_write(AW'(i), model[i], 6'h3F);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            sb.push_back('{data: model[i], err: 1'b0});
            tick();
            n_checks++;
            if (rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL stream_%0d valid got %b required 1", i, rd_valid);
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || rd_err !== e.err)
                    $display("FAIL stream_%0d got %h err %b required %h err %b", i, rd_data,
                             rd_err, e.data, e.err);
                else n_pass++;
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== model[15])
                $display("FAIL stream_hold_%0d got v=%b data=%h required v=0 data=%h", i,
                         rd_valid, rd_data, model[15]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        rd_en   = 1'b1;
        rd_addr = 12'd3;
        tick();
        rd_addr = 12'd4;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rd_data, rd_valid, rd_err, wr_err} !== '0)
            $display("FAIL reset_async got data=%h v=%b required 0", rd_data, rd_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0) $display("FAIL reset_discard got v=%b required 0", rd_valid);
        else n_pass++;
        idle();
        rst = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b0) $display("FAIL reset_release got v=%b required 0", rd_valid);
        else n_pass++;
        rd_en   = 1'b1;
        rd_addr = 12'd3;
        sb.push_back('{data: model[3], err: 1'b0});
        tick();
        idle();
        n_checks++;
        if (rd_valid !== 1'b1 || sb.size() == 0) begin
            $display("FAIL reset_retain valid got %b required 1", rd_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (rd_data !== e.data)
                $display("FAIL reset_retain got %h required %h", rd_data, e.data);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_basic();
        test_mask();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
